// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame decoder: FSM states, error codes, default SOF.
// No logic, no latency.
// Not applicable: no flow control in a package.
package uart_frame_pkg;

  // Decoder FSM states
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_SEND    = 3'd4
  } state_e;

  // Error codes reported on o_err_code
  localparam logic [1:0] ERR_LEN  = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  // Default start-of-frame marker
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Address width for a register file of the given depth (at least one bit)
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x WIDTH_DATA register file, synchronous write, registered read.
// Read data appears the cycle after re_i; write lands at the clock edge.
// No backpressure: single write and read port, both always accepted.
module uart_frame_buf #(
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [WIDTH_DATA-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [WIDTH_DATA-1:0] rdata_o
);

  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic [WIDTH_DATA-1:0] rdata_q;

  // Storage array: written on demand, deliberately left without reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: only loads when asked, so the output holds otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame decoder behind a UART rx buffer: SOF, length, payload, checksum; replays good payloads.
// First payload byte and o_ok appear one cycle after the checksum byte is consumed; 1 byte/clk.
// Upstream is stalled (o_re=0) while replaying; replay holds o_data/o_valid/o_last while i_ready=0.
// Optional inter-byte timeout is compiled in with `define UART_FRAME_RX_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned          WIDTH_DATA = 8,
  parameter int unsigned          MAX_LEN    = 16,
  parameter logic [WIDTH_DATA-1:0] SOF       = WIDTH_DATA'(SOF_DEFAULT),
  parameter int unsigned          TIMEOUT    = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [WIDTH_DATA-1:0] i_data,
  input  logic                  i_rdy,
  output logic                  o_re,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_ok,
  output logic                  o_err,
  output logic [1:0]            o_err_code
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = addr_width(MAX_LEN);
  localparam logic [WIDTH_DATA-1:0] MAX_LEN_W = WIDTH_DATA'(MAX_LEN);

  // Refuse to elaborate with a length range the counters cannot represent
  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_frame_rx: MAX_LEN must be 1..255 and TIMEOUT at least 1");
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         wr_q, wr_d;
  logic [CW-1:0]         rd_q, rd_d;
  logic [WIDTH_DATA-1:0] sum_q, sum_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic                  buf_we;
  logic                  buf_re;
  logic [AW-1:0]         buf_raddr;
  logic [WIDTH_DATA-1:0] buf_rdata;

  logic [WIDTH_DATA-1:0] csum_total;
  logic [CW-1:0]         len_last_idx;
  logic [CW-1:0]         rd_inc;
  logic                  len_bad;
  logic                  tmo_hit;

  // Pop only when a byte is there and we are not busy replaying
  assign o_re = i_rdy && (state_q != ST_SEND);

  assign csum_total   = sum_q + i_data;
  assign len_last_idx = len_q - CW'(1);
  assign rd_inc       = rd_q + CW'(1);
  assign len_bad      = (i_data == '0) || (i_data > MAX_LEN_W);

`ifdef UART_FRAME_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_frame;

  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  assign tmo_hit  = in_frame && !o_re && (tmo_q == TW'(TIMEOUT - 1));

  // Inter-byte counter: cleared by every pop, counts only while mid-frame
  always_comb begin
    tmo_d = '0;
    if (!o_re && in_frame) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Timeout counter register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM next state, counters, checksum and registered stream/pulse outputs
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    sum_d     = sum_q;
    valid_d   = valid_q;
    last_d    = last_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    buf_we    = 1'b0;
    buf_re    = 1'b0;
    buf_raddr = rd_inc[AW-1:0];

    unique case (state_q)
      ST_HUNT: begin
        if (o_re && (i_data == SOF)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (o_re) begin
          if (len_bad) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_HUNT;
          end else begin
            len_d   = i_data[CW-1:0];
            sum_d   = i_data;
            wr_d    = '0;
            state_d = ST_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = ERR_TMO;
          state_d = ST_HUNT;
        end
      end

      ST_PAYLOAD: begin
        if (o_re) begin
          buf_we = 1'b1;
          sum_d  = csum_total;
          if (wr_q == len_last_idx) begin
            state_d = ST_CSUM;
          end else begin
            wr_d = wr_q + CW'(1);
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = ERR_TMO;
          state_d = ST_HUNT;
        end
      end

      ST_CSUM: begin
        if (o_re) begin
          if (csum_total == '0) begin
            // Prefetch payload byte 0 so it is on o_data alongside o_ok
            ok_d      = 1'b1;
            valid_d   = 1'b1;
            last_d    = (len_q == CW'(1));
            rd_d      = '0;
            buf_re    = 1'b1;
            buf_raddr = '0;
            state_d   = ST_SEND;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
            state_d = ST_HUNT;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          code_d  = ERR_TMO;
          state_d = ST_HUNT;
        end
      end

      ST_SEND: begin
        if (valid_q && i_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            rd_d    = '0;
            wr_d    = '0;
            state_d = ST_HUNT;
          end else begin
            rd_d   = rd_inc;
            buf_re = 1'b1;
            last_d = (rd_inc == len_last_idx);
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_HUNT;
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_LEN;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  uart_frame_buf #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH      (MAX_LEN),
    .AW         (AW)
  ) u_buf (
    .clk_i   (i_clk),
    .rst_ni  (i_nrst),
    .we_i    (buf_we),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i (i_data),
    .re_i    (buf_re),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  assign o_data     = buf_rdata;
  assign o_valid    = valid_q;
  assign o_last     = last_q;
  assign o_ok       = ok_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx: uart buffer modelled as a byte queue, expected events in a scoreboard.
module tb_uart_frame_rx;

  localparam int WD  = 8;
  localparam int ML  = 16;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          nrst;
  logic [WD-1:0] i_data;
  logic          i_rdy;
  logic          o_re;
  logic [WD-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_last;
  logic          o_ok;
  logic          o_err;
  logic [1:0]    o_err_code;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .WIDTH_DATA (WD),
    .MAX_LEN    (ML),
    .SOF        (8'hA5),
    .TIMEOUT    (TMO)
  ) dut (
    .i_clk      (clk),
    .i_nrst     (nrst),
    .i_data     (i_data),
    .i_rdy      (i_rdy),
    .o_re       (o_re),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_ok       (o_ok),
    .o_err      (o_err),
    .o_err_code (o_err_code)
  );

  // Expected output events: kind 0 = ok pulse, 1 = error pulse (dat = code), 2 = payload byte
  typedef struct {
    int         kind;
    logic [7:0] dat;
    logic       last;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] up_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  bit rnd_mode = 1'b0;
  bit hold_en = 1'b0;
  int hold_cnt = 0;
  logic [1:0] model_code = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    up_q.push_back(b);
  endtask

  task automatic exp_ok();
    ev_t e;
    e.kind = 0; e.dat = 8'h00; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] code);
    ev_t e;
    e.kind = 1; e.dat = {6'd0, code}; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic exp_dat(input logic [7:0] b, input logic l);
    ev_t e;
    e.kind = 2; e.dat = b; e.last = l;
    exp_q.push_back(e);
  endtask

  // Frame generator: checksum makes len + payload + csum sum to 0 mod 256 unless csum_err != 0
  task automatic gen_frame(input int n, input logic [7:0] csum_err);
    logic [7:0] p[$];
    logic [7:0] s;
    s = 8'(n);
    for (int i = 0; i < n; i++) begin
      p.push_back(8'($urandom));
      s = s + p[i];
    end
    push(8'hA5);
    push(8'(n));
    foreach (p[i]) push(p[i]);
    push(8'(8'h00 - s) + csum_err);
    if (csum_err == 8'h00) begin
      exp_ok();
      for (int i = 0; i < n; i++) exp_dat(p[i], i == n - 1);
    end else begin
      exp_err(2'd1);
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0) && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", 32'(up_q.size() + exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_up(input int budget);
    int t = 0;
    while (up_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("upstream_drained", 32'(up_q.size()), 32'd0);
  endtask

  // Upstream uart buffer and downstream sink
  initial begin : driver
    bit pop_now;
    i_rdy = 1'b0;
    i_data = '0;
    i_ready = 1'b0;
    forever begin
      @(negedge clk);
      pop_now = i_rdy && o_re && nrst;
      @(posedge clk);
      #1;
      if (pop_now) begin
        void'(up_q.pop_front());
        last_pop_cyc = cyc;
      end
      if (up_q.size() > 0) begin
        i_data = up_q[0];
        i_rdy  = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        i_data = 8'($urandom);
        i_rdy  = 1'b0;
      end
      if (hold_en && o_valid && o_data == 8'h22 && hold_cnt < 5) begin
        i_ready = 1'b0;
        hold_cnt++;
      end else begin
        i_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  task automatic take(input int kind, input logic [7:0] dat, input logic last, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got data %0h last %0b, expected no event (cycle %0d)", nm, dat, last, cyc);
    end else begin
      e = exp_q.pop_front();
      chk({"kind_", nm}, 32'(kind), 32'(e.kind));
      if (e.kind == kind && kind == 1) begin
        chk("err_code", 32'(dat), 32'(e.dat));
        model_code = e.dat[1:0];
      end
      if (e.kind == kind && kind == 2) begin
        chk("data", 32'(dat), 32'(e.dat));
        chk("last", 32'(last), 32'(e.last));
      end
    end
  endtask

  // Monitor: compares every presented output against the scoreboard
  logic       pv, pr, pl, pok, perr;
  logic [7:0] pd;

  always @(negedge clk) begin
    if (!nrst) begin
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pok = 1'b0; perr = 1'b0; pd = '0;
      model_code = 2'd0;
    end else begin
      chk("o_re", 32'(o_re), 32'(i_rdy && !o_valid));
      if (pv && !pr) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", 32'(o_data), 32'(pd));
        chk("hold_last", 32'(o_last), 32'(pl));
      end
      if (pv && pr && !pl) chk("stream_gap", 32'(o_valid), 32'd1);
      if (pok) chk("ok_one_cycle", 32'(o_ok), 32'd0);
      if (perr) chk("err_one_cycle", 32'(o_err), 32'd0);
      if (o_ok) begin
        chk("ok_with_first_valid", 32'(o_valid), 32'd1);
        take(0, 8'h00, 1'b0, "ok");
      end
      if (o_err) begin
        take(1, {6'd0, o_err_code}, 1'b0, "err");
        if (o_err_code == 2'd2) chk("timeout_delay", 32'(cyc - last_pop_cyc), 32'(TMO));
      end else begin
        chk("err_code_hold", 32'(o_err_code), 32'(model_code));
      end
      if (o_valid && i_ready) take(2, o_data, o_last, "data");
      pv = o_valid; pr = i_ready; pl = o_last; pd = o_data; pok = o_ok; perr = o_err;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] good_f[6];
    logic [7:0] bad_f[6];
    logic [7:0] garb[3];
    int kind;
    good_f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    bad_f  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
    garb   = '{8'h00, 8'hFF, 8'h5A};
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_ok", 32'(o_ok), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_code", 32'(o_err_code), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    @(posedge clk);
    #2 nrst = 1'b1;

    // Reference good frame
    foreach (good_f[i]) push(good_f[i]);
    exp_ok(); exp_dat(8'h11, 1'b0); exp_dat(8'h22, 1'b0); exp_dat(8'h33, 1'b1);
    drain(200);

    // Bad checksum, then a good frame
    foreach (bad_f[i]) push(bad_f[i]);
    exp_err(2'd1);
    foreach (good_f[i]) push(good_f[i]);
    exp_ok(); exp_dat(8'h11, 1'b0); exp_dat(8'h22, 1'b0); exp_dat(8'h33, 1'b1);
    drain(200);

    // Bad lengths: zero and MAX_LEN+1, then a good frame proves return to hunting
    push(8'hA5); push(8'h00); exp_err(2'd0);
    push(8'hA5); push(8'h11); exp_err(2'd0);
    foreach (good_f[i]) push(good_f[i]);
    exp_ok(); exp_dat(8'h11, 1'b0); exp_dat(8'h22, 1'b0); exp_dat(8'h33, 1'b1);
    drain(200);

    // Leading garbage is silently discarded
    foreach (garb[i]) push(garb[i]);
    foreach (good_f[i]) push(good_f[i]);
    exp_ok(); exp_dat(8'h11, 1'b0); exp_dat(8'h22, 1'b0); exp_dat(8'h33, 1'b1);
    drain(200);

    // Downstream stall on byte 22 with another frame waiting upstream
    hold_en = 1'b1;
    hold_cnt = 0;
    foreach (good_f[i]) push(good_f[i]);
    exp_ok(); exp_dat(8'h11, 1'b0); exp_dat(8'h22, 1'b0); exp_dat(8'h33, 1'b1);
    push(8'hA5); push(8'h01); push(8'h44); push(8'hBB);
    exp_ok(); exp_dat(8'h44, 1'b1);
    drain(300);
    chk("hold_cycles", 32'(hold_cnt), 32'd5);
    hold_en = 1'b0;

    // Stall mid-payload: timeout error if compiled in, otherwise the frame simply resumes
`ifdef UART_FRAME_RX_TIMEOUT_EN
    exp_err(2'd2);
`else
    exp_ok(); exp_dat(8'h11, 1'b0); exp_dat(8'h22, 1'b1);
`endif
    push(8'hA5); push(8'h02); push(8'h11);
    wait_up(100);
    repeat (150) @(posedge clk);
    push(8'h22); push(8'hCB);
    drain(300);

    // Reset in the middle of a frame loses it without an error pulse
    push(8'hA5); push(8'h03); push(8'h11);
    wait_up(100);
    @(posedge clk);
    #2 nrst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_err", 32'(o_err), 32'd0);
    chk("midrst_code", 32'(o_err_code), 32'd0);
    @(posedge clk);
    #2 nrst = 1'b1;
    foreach (good_f[i]) push(good_f[i]);
    exp_ok(); exp_dat(8'h11, 1'b0); exp_dat(8'h22, 1'b0); exp_dat(8'h33, 1'b1);
    drain(200);

    // Length boundaries
    gen_frame(1, 8'h00);
    gen_frame(ML, 8'h00);
    drain(300);

    // Randomized mix with random upstream availability and downstream readiness
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        gen_frame($urandom_range(1, ML), 8'h00);
      end else if (kind < 8) begin
        gen_frame($urandom_range(1, ML), 8'($urandom_range(1, 255)));
      end else if (kind < 9) begin
        push(8'hA5);
        if ($urandom_range(0, 1) == 0) push(8'h00);
        else push(8'($urandom_range(ML + 1, 255)));
        exp_err(2'd0);
      end else begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          logic [7:0] b;
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h5A;
          push(b);
        end
      end
    end
    drain(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
